// File: rtl/bcrypt_expand_wr_seq_if.sv
// rtl/bcrypt_expand_wr_seq_if.sv - control, encryption handshake and RAM write bus of the ExpandKey write-back sequencer
interface bcrypt_expand_wr_seq_if;
    logic       start;
    logic       salt_mode;
    logic       busy;
    logic       done;
    logic       enc_start;
    logic       enc_done;
    logic       salt_xor;
    logic       salt_half;
    logic       wr_lr;
    logic       P_wr_en;
    logic [4:0] P_wr_addr;
    logic       S_wr_en;
    logic [9:0] S_wr_addr;

    modport master (
        input  start, salt_mode, enc_done,
        output busy, done, enc_start, salt_xor, salt_half, wr_lr,
               P_wr_en, P_wr_addr, S_wr_en, S_wr_addr
    );

    modport slave (
        output start, salt_mode, enc_done,
        input  busy, done, enc_start, salt_xor, salt_half, wr_lr,
               P_wr_en, P_wr_addr, S_wr_en, S_wr_addr
    );
endinterface

// File: rtl/bcrypt_expand_wr_seq.sv
// rtl/bcrypt_expand_wr_seq.sv - sequences 521 Blowfish encryptions and writes each L/R result into P then S
module bcrypt_expand_wr_seq #(
    parameter logic [4:0] P_ADDR_BASE = 5'd0,
    parameter int         P_PAIRS     = 9,
    parameter int         S_PAIRS     = 512
) (
    input  logic                      CLK,
    input  logic                      RST,
    bcrypt_expand_wr_seq_if.master    bus
);
    localparam logic [9:0] P_PAIRS_W = 10'(P_PAIRS);
    localparam logic [9:0] LAST_PAIR = 10'(P_PAIRS + S_PAIRS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WR_L,
        ST_WR_R,
        ST_FIN
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] pair;
    logic       salt_q;
    logic [4:0] p_addr;
    logic [9:0] s_addr;

    logic       in_p;
    logic       last_pair;
    logic [9:0] s_idx;
    logic [4:0] p_even;
    logic [9:0] s_even;

    assign in_p      = (pair < P_PAIRS_W);
    assign last_pair = (pair == LAST_PAIR);
    assign s_idx     = pair - P_PAIRS_W;
    assign p_even    = P_ADDR_BASE + 5'(pair << 1);
    assign s_even    = s_idx << 1;

    assign bus.salt_xor  = salt_q;
    assign bus.salt_half = pair[0];
    assign bus.P_wr_addr = p_addr;
    assign bus.S_wr_addr = s_addr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.enc_start = 1'b0;
        bus.wr_lr     = 1'b0;
        bus.P_wr_en   = 1'b0;
        bus.S_wr_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.busy      = 1'b1;
                bus.enc_start = 1'b1;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                bus.busy = 1'b1;
                if (bus.enc_done) begin
                    state_next = ST_WR_L;
                end
            end
            ST_WR_L: begin
                bus.busy    = 1'b1;
                bus.P_wr_en = in_p;
                bus.S_wr_en = ~in_p;
                state_next  = ST_WR_R;
            end
            ST_WR_R: begin
                bus.busy    = 1'b1;
                bus.wr_lr   = 1'b1;
                bus.P_wr_en = in_p;
                bus.S_wr_en = ~in_p;
                state_next  = last_pair ? ST_FIN : ST_REQ;
            end
            ST_FIN: begin
                bus.done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address registers load the even address as the core result lands, so they are valid with the strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pair   <= '0;
            salt_q <= 1'b0;
            p_addr <= P_ADDR_BASE;
            s_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        pair   <= '0;
                        salt_q <= bus.salt_mode;
                    end
                end
                ST_WAIT: begin
                    if (bus.enc_done) begin
                        if (in_p) begin
                            p_addr <= p_even;
                        end else begin
                            s_addr <= s_even;
                        end
                    end
                end
                ST_WR_L: begin
                    if (in_p) begin
                        p_addr <= p_addr + 5'd1;
                    end else begin
                        s_addr <= s_addr + 10'd1;
                    end
                end
                ST_WR_R: begin
                    if (!last_pair) begin
                        pair <= pair + 10'd1;
                    end
                end
                ST_FIN: begin
                    salt_q <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcrypt_expand_wr_seq.sv
// tb/tb_bcrypt_expand_wr_seq.sv - randomized self-checking bench for the ExpandKey write-back sequencer
module tb_bcrypt_expand_wr_seq;
    localparam logic [4:0] BASE = 5'd0;
    localparam int         NP   = 9;
    localparam int         NT   = 521;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    bcrypt_expand_wr_seq_if bus ();

    bcrypt_expand_wr_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_total = 0;
    int n_bad   = 0;
    int wr_cnt  = 0;
    int es_cnt  = 0;
    int dn_cnt  = 0;
    int bh_cnt  = 0;

    always @(negedge CLK) begin
        if (bus.P_wr_en || bus.S_wr_en) wr_cnt <= wr_cnt + 1;
        if (bus.enc_start)              es_cnt <= es_cnt + 1;
        if (bus.done)                   dn_cnt <= dn_cnt + 1;
        if (bus.P_wr_en && bus.S_wr_en) bh_cnt <= bh_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected write target derived directly from the pair index and half.
    task automatic expect_write(input int p, input bit lr);
        if (p < NP) begin
            check("p_en", 32'(bus.P_wr_en), 32'd1);
            check("s_en_in_p", 32'(bus.S_wr_en), 32'd0);
            check("p_addr", 32'(bus.P_wr_addr), 32'(BASE) + 32'(2 * p + int'(lr)));
        end else begin
            check("s_en", 32'(bus.S_wr_en), 32'd1);
            check("p_en_in_s", 32'(bus.P_wr_en), 32'd0);
            check("s_addr", 32'(bus.S_wr_addr), 32'(2 * (p - NP) + int'(lr)));
        end
        check("wr_lr", 32'(bus.wr_lr), 32'(lr));
    endtask

    task automatic run_seq(input bit salt, input bit b2b, input bit noisy,
                           input int hold_pair, input int abort_pair, input int fixed_dly);
        int wr0, es0, dn0, bh0, dly;
        wr0 = wr_cnt; es0 = es_cnt; dn0 = dn_cnt; bh0 = bh_cnt;
        bus.salt_mode = salt;
        bus.start     = 1'b1;
        if (b2b) begin
            tick();
            check("b2b_idle", 32'({bus.busy, bus.enc_start}), 32'd0);
        end
        tick();
        bus.start     = 1'b0;
        bus.salt_mode = ~salt;
        for (int p = 0; p < NT; p++) begin
            check("enc_start", 32'(bus.enc_start), 32'd1);
            check("busy", 32'(bus.busy), 32'd1);
            check("salt_xor", 32'(bus.salt_xor), 32'(salt));
            check("salt_half", 32'(bus.salt_half), 32'(p % 2));
            bus.enc_done = noisy;
            if (p == hold_pair)     dly = 100;
            else if (fixed_dly > 0) dly = fixed_dly;
            else                    dly = int'($urandom_range(1, 6));
            for (int k = 1; k <= dly; k++) begin
                tick();
                bus.enc_done = 1'b0;
                bus.start    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                if (p == abort_pair) begin
                    RST          = 1'b1;
                    bus.enc_done = 1'b1;
                    bus.start    = 1'b0;
                    tick();
                    RST = 1'b0;
                    check("rst_busy", 32'(bus.busy), 32'd0);
                    check("rst_s_addr", 32'(bus.S_wr_addr), 32'd0);
                    check("rst_p_addr", 32'(bus.P_wr_addr), 32'(BASE));
                    check("rst_outs", 32'({bus.enc_start, bus.done, bus.salt_xor,
                                           bus.P_wr_en, bus.S_wr_en}), 32'd0);
                    bus.enc_done = 1'b1;
                    tick();
                    bus.enc_done = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        check("late_done_quiet", 32'({bus.busy, bus.P_wr_en, bus.S_wr_en,
                                                      bus.enc_start}), 32'd0);
                        tick();
                    end
                    return;
                end
                check("wait_quiet", 32'({bus.P_wr_en, bus.S_wr_en, bus.enc_start, bus.done}), 32'd0);
            end
            bus.enc_done = 1'b1;
            tick();
            bus.enc_done = noisy;
            bus.start    = 1'b0;
            expect_write(p, 1'b0);
            tick();
            bus.enc_done = 1'b0;
            expect_write(p, 1'b1);
            tick();
        end
        check("done", 32'(bus.done), 32'd1);
        check("busy_fin", 32'(bus.busy), 32'd0);
        check("enc_start_fin", 32'(bus.enc_start), 32'd0);
        @(negedge CLK);
        #1;
        check("write_count", 32'(wr_cnt - wr0), 32'd1042);
        check("enc_start_count", 32'(es_cnt - es0), 32'd521);
        check("done_count", 32'(dn_cnt - dn0), 32'd1);
        check("both_strobes", 32'(bh_cnt - bh0), 32'd0);
    endtask

    initial begin
        RST           = 1'b1;
        bus.start     = 1'b0;
        bus.salt_mode = 1'b0;
        bus.enc_done  = 1'b0;
        tick();
        tick();
        check("reset_ctl", 32'({bus.busy, bus.done, bus.enc_start, bus.wr_lr}), 32'd0);
        check("reset_strobes", 32'({bus.P_wr_en, bus.S_wr_en}), 32'd0);
        check("reset_salt", 32'({bus.salt_xor, bus.salt_half}), 32'd0);
        check("reset_p_addr", 32'(bus.P_wr_addr), 32'(BASE));
        check("reset_s_addr", 32'(bus.S_wr_addr), 32'd0);
        RST = 1'b0;
        tick();

        run_seq(1'b0, 1'b0, 1'b0, -1, -1, 4);
        run_seq(1'b1, 1'b1, 1'b0, 3, -1, 0);
        tick();
        tick();
        run_seq(1'b0, 1'b0, 1'b1, -1, -1, 0);
        tick();
        run_seq(1'b1, 1'b0, 1'b0, -1, 300, 0);
        tick();
        run_seq(1'($urandom_range(0, 1)), 1'b0, 1'b1, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
